// File: rtl/m_pool_pkg.sv
// m_pool_pkg: shared types and constants for the 2x2/stride-2 max-pool block.
// Holds the FSM state enum and the window-offset table used to walk one window.
package m_pool_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      DRAIN,
      OUT,
      FIN
   } state_e;

   localparam int WIN_N = 4;

   // Window visit order is base, base+1, base+IMG_W+1, base+IMG_W.
   // Bit k of each mask is the column / row step taken by beat k.
   localparam logic [WIN_N-1:0] WIN_DX = 4'b0110;
   localparam logic [WIN_N-1:0] WIN_DY = 4'b1100;

   function automatic int unsigned win_off(input logic [1:0] beat, input int unsigned img_w);
      return (WIN_DY[beat] ? img_w : 32'd0) + (WIN_DX[beat] ? 32'd1 : 32'd0);
   endfunction

endpackage

// File: rtl/m_pool_relu_gen_if.sv
// m_pool_relu_gen_if: RAM read port, result stream and run control of the pool block.
// master = the pool engine, slave = RAM model / downstream consumer / controller.
interface m_pool_relu_gen_if #(
   parameter int DATA_W = 8,
   parameter int AW     = 10
);
   logic              start;
   logic              rd_en;
   logic [AW-1:0]     rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] d_out;
   logic              d_valid;
   logic              d_ready;
   logic              busy;
   logic              done;

   modport master (
      input  start, rd_data, d_ready,
      output rd_en, rd_addr, d_out, d_valid, busy, done
   );

   modport slave (
      output start, rd_data, d_ready,
      input  rd_en, rd_addr, d_out, d_valid, busy, done
   );
endinterface

// File: rtl/m_pool_addr_gen.sv
// m_pool_addr_gen: column / row-pair / channel counters and the running window base.
// The base is kept incrementally: +2 within a row pair, +IMG_W+2 at every column wrap
// (which also lands exactly on the next channel after the last row pair), 0 after the
// last window so a finished run leaves the counters ready for the next start.
module m_pool_addr_gen #(
   parameter int IMG_W = 26,
   parameter int IMG_H = 26,
   parameter int CH    = 1,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          advance_i,
   output logic [AW-1:0] base_o,
   output logic          last_o
);
   localparam int NCOL = IMG_W / 2;
   localparam int NROW = IMG_H / 2;
   localparam int CLW  = (NCOL > 1) ? $clog2(NCOL) : 1;
   localparam int RW   = (NROW > 1) ? $clog2(NROW) : 1;
   localparam int CHW  = (CH > 1)   ? $clog2(CH)   : 1;

   logic [CLW-1:0] col_q, col_d;
   logic [RW-1:0]  row_q, row_d;
   logic [CHW-1:0] ch_q,  ch_d;
   logic [AW-1:0]  base_q, base_d;
   logic           col_last, row_last, ch_last;

   assign col_last = (col_q == CLW'(NCOL - 1));
   assign row_last = (row_q == RW'(NROW - 1));
   assign ch_last  = (ch_q  == CHW'(CH - 1));
   assign last_o   = col_last & row_last & ch_last;
   assign base_o   = base_q;

   // next window position on each accepted result
   always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      ch_d   = ch_q;
      base_d = base_q;
      if (advance_i) begin
         if (last_o) begin
            col_d  = '0;
            row_d  = '0;
            ch_d   = '0;
            base_d = '0;
         end else if (col_last) begin
            col_d  = '0;
            base_d = base_q + AW'(IMG_W + 2);
            if (row_last) begin
               row_d = '0;
               ch_d  = ch_q + 1'b1;
            end else begin
               row_d = row_q + 1'b1;
            end
         end else begin
            col_d  = col_q + 1'b1;
            base_d = base_q + AW'(2);
         end
      end
   end

   // counter registers, cleared by synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         col_q  <= '0;
         row_q  <= '0;
         ch_q   <= '0;
         base_q <= '0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         ch_q   <= ch_d;
         base_q <= base_d;
      end
   end
endmodule

// File: rtl/m_pool_relu_gen.sv
// m_pool_relu_gen: 2x2 stride-2 signed max pooling over a planar feature map in RAM.
// Each window takes READ(4) + DRAIN(1) + OUT(>=1) cycles. Build option M_POOL_RELU_EN
// clamps negative window maxima to zero; timing is the same with or without it.
module m_pool_relu_gen
   import m_pool_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 26,
   parameter int IMG_H  = 26,
   parameter int CH     = 1
) (
   input logic               clk,
   input logic               rst,
   m_pool_relu_gen_if.master bus
);
   localparam int AW = $clog2(CH * IMG_W * IMG_H);

   state_e                    state_q, state_d;
   logic [1:0]                beat_q, beat_d;
   logic                      dvld_q, first_q;
   logic signed [DATA_W-1:0]  max_q, max_d;
   logic signed [DATA_W-1:0]  dout_q, dout_d;
   logic                      adv, last;
   logic [AW-1:0]             base;

   function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v);
`ifdef M_POOL_RELU_EN
      return v[DATA_W-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   assign adv = (state_q == OUT) && bus.d_ready;

   m_pool_addr_gen #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .CH    (CH),
      .AW    (AW)
   ) u_addr (
      .clk       (clk),
      .rst       (rst),
      .advance_i (adv),
      .base_o    (base),
      .last_o    (last)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // next state: start only heard in IDLE, so it is ignored while busy
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = READ;
         READ:    if (beat_q == 2'd3) state_d = DRAIN;
         DRAIN:   state_d = OUT;
         OUT:     if (bus.d_ready) state_d = last ? FIN : READ;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // beat counter, running max (seeded by the first sample) and result capture
   always_comb begin
      beat_d = (state_q == READ) ? beat_q + 2'd1 : 2'd0;
      max_d  = max_q;
      if (dvld_q && (first_q || ($signed(bus.rd_data) > max_q)))
         max_d = $signed(bus.rd_data);
      dout_d = dout_q;
      if (state_q == DRAIN)
         dout_d = relu(max_d);
   end

   // datapath registers; read data returns one cycle after rd_en
   always_ff @(posedge clk) begin
      if (!rst) begin
         beat_q  <= '0;
         dvld_q  <= 1'b0;
         first_q <= 1'b0;
         max_q   <= '0;
         dout_q  <= '0;
      end else begin
         beat_q  <= beat_d;
         dvld_q  <= (state_q == READ);
         first_q <= (state_q == READ) && (beat_q == 2'd0);
         max_q   <= max_d;
         dout_q  <= dout_d;
      end
   end

   assign bus.rd_en   = (state_q == READ);
   assign bus.rd_addr = base + AW'(win_off(beat_q, IMG_W));
   assign bus.d_out   = dout_q;
   assign bus.d_valid = (state_q == OUT);
   assign bus.busy    = (state_q != IDLE);
   assign bus.done    = (state_q == FIN);
endmodule

// File: tb/tb_m_pool_relu_gen.sv
// tb_m_pool_relu_gen: directed bench with a result scoreboard for the pool block.
// u0: 4x4, one channel.  u1: 4x4, two channels.
`timescale 1ns/1ps
module tb_m_pool_relu_gen;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   m_pool_relu_gen_if #(.DATA_W(8), .AW(4)) if0 ();
   m_pool_relu_gen_if #(.DATA_W(8), .AW(5)) if1 ();

   m_pool_relu_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .CH(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
   m_pool_relu_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .CH(2)) u1 (.clk(clk), .rst(rst), .bus(if1));

   logic [7:0] ram0 [16];
   logic [7:0] ram1 [32];

   // synchronous RAM models, one-cycle read latency
   always @(posedge clk) begin
      if (if0.rd_en) if0.rd_data <= ram0[if0.rd_addr];
      if (if1.rd_en) if1.rd_data <= ram1[if1.rd_addr];
   end

   int nvec = 0, nerr = 0, cyc = 0;
   logic [7:0] q0 [$];
   logic [7:0] q1 [$];
   int nres0 = 0, ndone0 = 0, hs0 = 0, last0 = 0, nwin0 = 0, beat0 = 0;
   int nres1 = 0, ndone1 = 0, nwin1 = 0, beat1 = 0, maxa1 = 0;
   bit have0 = 0, steady0 = 0, rdp0 = 0, dvp0 = 0, hold0 = 0, rdp1 = 0;
   logic [7:0] hold_do0 = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // address of beat b of window w in a 4x4 plane stack
   function automatic int exp_addr(input int w, input int b);
      int off [4] = '{0, 1, 5, 4};
      int c, r, col;
      c = w / 4; r = (w % 4) / 2; col = w % 2;
      if (b > 3) return -1;
      return c * 16 + 2 * r * 4 + 2 * col + off[b];
   endfunction

   function automatic logic [7:0] rd(input int sel, input int a);
      return (sel != 0) ? ram1[a] : ram0[a];
   endfunction

   task automatic push_exp(input int sel, input int nw, input int w0);
      for (int w = w0; w < nw; w++) begin
         logic signed [7:0] m, v;
         m = rd(sel, exp_addr(w, 0));
         for (int b = 1; b < 4; b++) begin
            v = rd(sel, exp_addr(w, b));
            if (v > m) m = v;
         end
`ifdef M_POOL_RELU_EN
         if (m < 0) m = 0;
`endif
         if (sel == 0) q0.push_back(m); else q1.push_back(m);
      end
   endtask

   task automatic mon();
      if (hold0) begin
         chk("hold_valid", 32'(if0.d_valid), 1);
         chk("hold_dout", 32'(if0.d_out), 32'(hold_do0));
         chk("hold_no_rd_en", 32'(if0.rd_en), 0);
      end
      hold0 = if0.d_valid && !if0.d_ready;
      hold_do0 = if0.d_out;
      if (if0.rd_en) begin
         if (!rdp0) begin
            if (steady0 && have0) chk("period", cyc - last0, 6);
            last0 = cyc; have0 = 1; beat0 = 0; nwin0++;
         end else beat0++;
         chk("addr0", 32'(if0.rd_addr), exp_addr(nwin0 - 1, beat0));
      end
      rdp0 = if0.rd_en;
      if (if0.d_valid && !dvp0) chk("latency", cyc - last0, 5);
      dvp0 = if0.d_valid;
      if (if0.d_valid && if0.d_ready) begin
         if (q0.size() == 0) chk("q0_underflow", 1, 0);
         else chk("dout0", 32'(if0.d_out), 32'(q0.pop_front()));
         nres0++; hs0 = cyc;
      end
      if (if0.done) begin
         chk("done_lat", cyc - hs0, 1);
         ndone0++;
      end
      if (if1.rd_en) begin
         if (!rdp1) begin
            beat1 = 0; nwin1++;
            if (nwin1 == 5) chk("ch1_start_addr", 32'(if1.rd_addr), 16);
         end else beat1++;
         chk("addr1", 32'(if1.rd_addr), exp_addr(nwin1 - 1, beat1));
         if (int'(if1.rd_addr) > maxa1) maxa1 = int'(if1.rd_addr);
      end
      rdp1 = if1.rd_en;
      if (if1.d_valid && if1.d_ready) begin
         if (q1.size() == 0) chk("q1_underflow", 1, 0);
         else chk("dout1", 32'(if1.d_out), 32'(q1.pop_front()));
         nres1++;
      end
      if (if1.done) ndone1++;
   endtask

   task automatic tick();
      mon();
      @(negedge clk);
      cyc++;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rd_en"},   32'(if0.rd_en), 0);
      chk({tag, "_rd_addr"}, 32'(if0.rd_addr), 0);
      chk({tag, "_d_out"},   32'(if0.d_out), 0);
      chk({tag, "_d_valid"}, 32'(if0.d_valid), 0);
      chk({tag, "_busy"},    32'(if0.busy), 0);
      chk({tag, "_done"},    32'(if0.done), 0);
   endtask

   // full run on u0; extra_at >= 0 pulses start again mid-run
   task automatic run0(input bit steady, input int extra_at);
      int d, r;
      d = ndone0; r = nres0;
      nwin0 = 0; have0 = 0; steady0 = steady;
      if0.start = 1'b1; tick(); if0.start = 1'b0;
      chk("busy_after_start", 32'(if0.busy), 1);
      for (int i = 0; i < 200 && ndone0 == d; i++) begin
         if0.start = (i == extra_at);
         tick();
      end
      if0.start = 1'b0;
      chk("run0_done", ndone0 - d, 1);
      chk("run0_count", nres0 - r, 4);
      chk("run0_q_empty", q0.size(), 0);
      chk("run0_busy_end", 32'(if0.busy), 0);
      chk("run0_done_pulse", 32'(if0.done), 0);
   endtask

   task automatic load_ramp();
      for (int i = 0; i < 16; i++) ram0[i] = 8'(i);
      q0.delete();
      q0.push_back(8'd5); q0.push_back(8'd7); q0.push_back(8'd13); q0.push_back(8'd15);
   endtask

   initial begin
      int d, n;
      rst = 1'b0;
      if0.start = 1'b0; if0.d_ready = 1'b1;
      if1.start = 1'b0; if1.d_ready = 1'b1;
      for (int i = 0; i < 16; i++) ram0[i] = '0;
      for (int i = 0; i < 32; i++) ram1[i] = '0;
      repeat (3) tick();
      chk_zero("reset");
      rst = 1'b1;
      tick();

      // ramp 0..15 -> 5, 7, 13, 15
      load_ramp();
      run0(1'b1, -1);

      // all-negative first window: -1, or 0 with ReLU
      for (int i = 0; i < 16; i++) ram0[i] = 8'($urandom_range(0, 255));
      ram0[0] = 8'hFD; ram0[1] = 8'hFF; ram0[5] = 8'hF8; ram0[4] = 8'hFE;
`ifdef M_POOL_RELU_EN
      q0.push_back(8'h00);
`else
      q0.push_back(8'hFF);
`endif
      push_exp(0, 4, 1);
      run0(1'b1, -1);

      // backpressure: d_ready low for 10 cycles in OUT
      for (int i = 0; i < 16; i++) ram0[i] = 8'($urandom_range(0, 255));
      push_exp(0, 4, 0);
      d = ndone0;
      nwin0 = 0; have0 = 0; steady0 = 0;
      if0.d_ready = 1'b0;
      if0.start = 1'b1; tick(); if0.start = 1'b0;
      for (int i = 0; i < 20 && !if0.d_valid; i++) tick();
      chk("bp_valid", 32'(if0.d_valid), 1);
      repeat (10) tick();
      n = nres0;
      if0.d_ready = 1'b1;
      tick();
      chk("bp_accept_first_high", nres0 - n, 1);
      for (int i = 0; i < 200 && ndone0 == d; i++) tick();
      chk("bp_done", ndone0 - d, 1);
      chk("bp_q_empty", q0.size(), 0);

      // start pulsed while busy is ignored
      load_ramp();
      run0(1'b1, 10);
      repeat (5) tick();
      chk("no_restart_busy", 32'(if0.busy), 0);

      // two channels on u1
      for (int i = 0; i < 32; i++) ram1[i] = 8'($urandom_range(0, 255));
      push_exp(1, 8, 0);
      d = ndone1; n = nres1; nwin1 = 0; maxa1 = 0;
      if1.start = 1'b1; tick(); if1.start = 1'b0;
      for (int i = 0; i < 300 && ndone1 == d; i++) tick();
      chk("ch2_done", ndone1 - d, 1);
      chk("ch2_count", nres1 - n, 8);
      chk("ch2_max_addr_ok", 32'(maxa1 <= 31), 1);
      chk("ch2_q_empty", q1.size(), 0);

      // abort in the second READ cycle, then a clean rerun
      load_ramp();
      nwin0 = 0; have0 = 0; steady0 = 1;
      if0.start = 1'b1; tick(); if0.start = 1'b0;
      tick();
      chk("abort_in_read", 32'(if0.rd_en), 1);
      rst = 1'b0;
      tick();
      chk_zero("abort");
      rst = 1'b1;
      d = ndone0;
      repeat (10) tick();
      chk("abort_no_done", ndone0 - d, 0);
      load_ramp();
      run0(1'b1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/m_pool_relu_gen.md
M_POOL_RELU_GEN -- requirements
Module: m_pool_relu_gen

Interface
REQ-001 Parameter DATA_W, default 8: signed two's-complement sample width.
REQ-002 Parameter IMG_W, default 26: input plane width in pixels; even and at least 2.
REQ-003 Parameter IMG_H, default 26: input plane height in pixels; even and at least 2.
REQ-004 Parameter CH, default 1: number of planar channels stored consecutively in RAM.
REQ-005 Localparam AW = clog2(CH*IMG_W*IMG_H), the RAM address width.
REQ-006 clk  in  1  clock; all logic is rising-edge.
REQ-007 rst  in  1  synchronous reset, active-low.
REQ-008 start  in  1  single-cycle request to pool the whole feature map.
REQ-009 rd_en  out  1  RAM read strobe.
REQ-010 rd_addr  out  AW  RAM read address.
REQ-011 rd_data  in  DATA_W  RAM read data, valid exactly 1 cycle after rd_en.
REQ-012 d_out  out  DATA_W  pooled result.
REQ-013 d_valid  out  1  d_out holds a valid result.
REQ-014 d_ready  in  1  downstream accepts d_out.
REQ-015 busy  out  1  high from the cycle after start is accepted until done.
REQ-016 done  out  1  one-cycle pulse after the last result is accepted.

Function
REQ-017 The block SHALL perform 2x2 pooling with stride 2 on each channel, giving (IMG_W/2)*(IMG_H/2)*CH results.
REQ-018 Results SHALL be produced channel-major, then row, then column.
REQ-019 The window addresses SHALL be base, base+1, base+IMG_W+1, base+IMG_W, in that order, where base = c*IMG_W*IMG_H + 2*r*IMG_W + 2*col.
REQ-020 The FSM SHALL have the states IDLE, READ, DRAIN, OUT and FIN.
REQ-021 IDLE->READ on start; READ lasts 4 cycles with rd_en high; READ->DRAIN; DRAIN->OUT.
REQ-022 OUT holds d_valid high until d_ready is sampled high. OUT then goes to READ for the next window, or to FIN after the last window.
REQ-023 FIN SHALL pulse done for 1 cycle and return to IDLE.
REQ-024 The running maximum SHALL be loaded with the first sample of each window, not with zero, and compared signed at full DATA_W.
REQ-025 With the first rd_en of a window in cycle t, d_valid SHALL be high in cycle t+5. With d_ready held high, one result is produced every 6 cycles.
REQ-026 d_out and d_valid SHALL remain stable while d_valid is high and d_ready is low.
REQ-027 start SHALL be ignored while busy is high.
REQ-028 rd_en SHALL be low in every state other than READ.
REQ-029 At the last column the address counters SHALL wrap to the next row pair, and at the last row pair to the next channel; the counters SHALL never exceed CH*IMG_W*IMG_H-1.

Reset
REQ-030 When rst is low, the next edge SHALL force IDLE, including mid-window.
REQ-031 The same edge SHALL force rd_en, rd_addr, d_out, d_valid, busy, done and all counters to 0.
REQ-032 An aborted run SHALL NOT produce a done pulse.

Configuration
REQ-033 With M_POOL_RELU_EN defined, a negative window maximum SHALL be output as 0.
REQ-034 Without M_POOL_RELU_EN, the signed maximum SHALL be output unmodified; timing is identical in both builds.

Structure
REQ-035 Package m_pool_pkg SHALL hold the FSM state enum and the window-offset constants.
REQ-036 The address/index counters SHALL be a sub-module, m_pool_addr_gen, with an advance input and a last-window flag output.

Verification
REQ-037 IMG_W=IMG_H=4, CH=1, RAM 0..15, d_ready=1 -> outputs 5,7,13,15; done 1 cycle after the 4th handshake.
REQ-038 Window {-3,-1,-8,-2}: with M_POOL_RELU_EN -> 0; without -> -1 (0xFF).
REQ-039 d_ready held low 10 cycles in OUT -> d_out stable, no rd_en, result accepted on the first high cycle.
REQ-040 CH=2, 4x4 -> rd_addr of result 5 starts at 16; 8 results total; rd_addr never exceeds 31.
REQ-041 rst low during the second READ cycle -> all outputs 0 next cycle, no done; a fresh start then reproduces scenario 1 exactly.
REQ-042 start pulsed while busy -> ignored; result count unchanged.
